// File: rtl/serializer_out.sv
// serializer_out: parallel-in, serial-out transmitter.
//
// A Width-bit word is captured on an accepted start_i. It is then shifted out
// on sdata_o one bit per ClkDiv clock cycles. valid_o qualifies the frame bits.
// done_o pulses for one cycle after the last bit period.
//
// Parameters:
//   Width    - word length in bits (>= 2)
//   ClkDiv   - clk_i cycles each bit is held on sdata_o (>= 1)
//   MsbFirst - 1: data_i[Width-1] goes first; 0: data_i[0] goes first
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - asynchronous, active-low reset
//   start_i - launch request, honoured only while idle
//   data_i  - word to transmit, captured on an accepted start
//   sdata_o - registered serial data
//   valid_o - high while sdata_o carries a frame bit
//   busy_o  - high while a frame is in progress
//   done_o  - one-cycle pulse after the final bit period
module serializer_out #(
    parameter int Width    = 8,
    parameter int ClkDiv   = 1,
    parameter int MsbFirst = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] data_i,
    output logic             sdata_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int BitW = $clog2(Width);
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(Width - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [Width-1:0]  shift_q, shift_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic              sdata_q, sdata_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sdata_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sdata_q   <= sdata_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sdata_d   = sdata_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                sdata_d = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    shift_d   = data_i;
                    // First bit comes straight from data_i so it is visible
                    // one cycle after start is sampled.
                    sdata_d   = (MsbFirst != 0) ? data_i[Width-1] : data_i[0];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BitLast) begin
                        state_d = IDLE;
                        sdata_d = 1'b0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // The next bit is the neighbour of the one on the line.
                        // It is taken from shift_q before the shift lands.
                        if (MsbFirst != 0) begin
                            shift_d = {shift_q[Width-2:0], 1'b0};
                            sdata_d = shift_q[Width-2];
                        end else begin
                            shift_d = {1'b0, shift_q[Width-1:1]};
                            sdata_d = shift_q[1];
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign sdata_o = sdata_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_serializer_out.sv
// tb_serializer_out: self-checking bench for serializer_out.
//
// Three instances cover the configurations that matter:
//   u0: Width=8, ClkDiv=1, MsbFirst=1
//   u1: Width=8, ClkDiv=4, MsbFirst=1
//   u2: Width=8, ClkDiv=1, MsbFirst=0
// Expected waveforms come from a cycle-indexed frame model. Bit b of a frame
// occupies cycles b*ClkDiv+1 .. (b+1)*ClkDiv after the start edge. done_o
// follows in cycle 8*ClkDiv+1.
module tb_serializer_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_s [3];
    logic [7:0] data_s  [3];
    logic       sdata_w [3];
    logic       valid_w [3];
    logic       busy_w  [3];
    logic       done_w  [3];

    int n_cmp = 0;
    int n_err = 0;

    serializer_out #(.Width(8), .ClkDiv(1), .MsbFirst(1)) u0 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_s[0]), .data_i(data_s[0]),
        .sdata_o(sdata_w[0]), .valid_o(valid_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
    );
    serializer_out #(.Width(8), .ClkDiv(4), .MsbFirst(1)) u1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_s[1]), .data_i(data_s[1]),
        .sdata_o(sdata_w[1]), .valid_o(valid_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
    );
    serializer_out #(.Width(8), .ClkDiv(1), .MsbFirst(0)) u2 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_s[2]), .data_i(data_s[2]),
        .sdata_o(sdata_w[2]), .valid_o(valid_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2])
    );

    function automatic int div_of(input int idx);
        return (idx == 1) ? 4 : 1;
    endfunction

    function automatic bit msb_of(input int idx);
        return (idx != 2);
    endfunction

    // Expected {sdata, valid, busy, done} in cycle k after a start for word w.
    function automatic logic [3:0] model(input int idx, input logic [7:0] w, input int k);
        int d;
        int n;
        int b;
        logic bitv;
        d = div_of(idx);
        n = 8 * d;
        if (k >= 1 && k <= n) begin
            b = (k - 1) / d;
            bitv = msb_of(idx) ? w[7 - b] : w[b];
            return {bitv, 3'b110};
        end
        if (k == n + 1) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] obs(input int idx);
        return {sdata_w[idx], valid_w[idx], busy_w[idx], done_w[idx]};
    endfunction

    task automatic test_reset();
        logic [3:0] o;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) data_s[i] = 8'($urandom);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            n_cmp++;
            if (o !== 4'b0000) begin
                n_err++;
                $display("FAIL reset u%0d: got %b want 0000 (sdata,valid,busy,done)", i, o);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            n_cmp++;
            if (o !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_after_reset u%0d: got %b want 0000", i, o);
            end
        end
    endtask

    task automatic test_single_frame(input int idx, input logic [7:0] w, input string name);
        logic [3:0] e;
        logic [3:0] o;
        int n;
        n = 8 * div_of(idx) + 3;
        @(posedge clk); #1;
        start_s[idx] = 1'b1;
        data_s[idx]  = w;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start_s[idx] = 1'b0;
            data_s[idx]  = 8'($urandom);
            @(negedge clk);
            e = model(idx, w, k);
            o = obs(idx);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s u%0d word %h cyc %0d: got %b want %b", name, idx, w, k, o, e);
            end
        end
    endtask

    task automatic test_msb_first();
        test_single_frame(0, 8'hA5, "msb_first");
        for (int r = 0; r < 3; r++) test_single_frame(0, 8'($urandom), "msb_first_rand");
    endtask

    task automatic test_clkdiv();
        test_single_frame(1, 8'h3C, "clkdiv4");
        for (int r = 0; r < 2; r++) test_single_frame(1, 8'($urandom), "clkdiv4_rand");
    endtask

    task automatic test_lsb_first();
        test_single_frame(2, 8'h01, "lsb_first");
        for (int r = 0; r < 3; r++) test_single_frame(2, 8'($urandom), "lsb_first_rand");
    endtask

    task automatic test_ignore_start();
        logic [3:0] e;
        logic [3:0] o;
        int extra;
        int dones;
        extra = $urandom_range(2, 8);
        dones = 0;
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        data_s[0]  = 8'hF0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            start_s[0] = (k == 4 || k == extra);
            data_s[0]  = 8'hFF;
            @(negedge clk);
            e = model(0, 8'hF0, k);
            o = obs(0);
            if (done_w[0] === 1'b1) dones++;
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL ignore_start cyc %0d: got %b want %b", k, o, e);
            end
        end
        start_s[0] = 1'b0;
        n_cmp++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL ignore_start_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back(input int idx, input logic [7:0] w1, input logic [7:0] w2);
        logic [3:0] e;
        logic [3:0] o;
        int n1;
        n1 = 8 * div_of(idx) + 1;
        @(posedge clk); #1;
        start_s[idx] = 1'b1;
        data_s[idx]  = w1;
        for (int k = 1; k <= 2 * n1 + 2; k++) begin
            @(posedge clk); #1;
            start_s[idx] = (k == n1);
            data_s[idx]  = (k == n1) ? w2 : 8'($urandom);
            @(negedge clk);
            e = (k <= n1) ? model(idx, w1, k) : model(idx, w2, k - n1);
            o = obs(idx);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL back_to_back u%0d %h/%h cyc %0d: got %b want %b", idx, w1, w2, k, o, e);
            end
        end
        start_s[idx] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] e;
        logic [3:0] o;
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        data_s[0]  = 8'hAA;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            start_s[0] = 1'b0;
            @(negedge clk);
            e = model(0, 8'hAA, k);
            o = obs(0);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rst_pre cyc %0d: got %b want %b", k, o, e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = obs(0);
        n_cmp++;
        if (o !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_async_immediate: got %b want 0000", o);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            o = obs(0);
            n_cmp++;
            if (o !== 4'b0000) begin
                n_err++;
                $display("FAIL rst_held %0d: got %b want 0000", k, o);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            o = obs(0);
            n_cmp++;
            if (o !== 4'b0000) begin
                n_err++;
                $display("FAIL rst_no_done %0d: got %b want 0000", k, o);
            end
        end
        test_single_frame(0, 8'h81, "rst_restart");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            data_s[i]  = 8'h00;
        end
        test_reset();
        test_msb_first();
        test_clkdiv();
        test_lsb_first();
        test_ignore_start();
        test_back_to_back(0, 8'hFF, 8'h00);
        test_back_to_back(1, 8'($urandom), 8'($urandom));
        test_back_to_back(2, 8'($urandom), 8'($urandom));
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
